apb_req_master: RTL and testbench

APB_REQ_MASTER -- requirements
Module: apb_req_master

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_slv_mux.sv | 52 +++++
 rtl/apb_req_master.sv | 189 ++++++++++++++++++
 tb/tb_apb_req_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB request master and its slave mux.
//   apb_state_t : transfer FSM encoding (IDLE / SETUP / ACCESS)
//   apb_sel_w() : width of the slave index, $clog2 of the slave count
//   apb_rsp_t   : registered response flags (the read data travels beside it
//                 because its width is chosen per instance)
// -----------------------------------------------------------------------------
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   // Number of address MSBs used to pick a slave (SEL_W = $clog2(NSLV)).
   function automatic int apb_sel_w(input int nslv);
      return $clog2(nslv);
   endfunction

   typedef struct packed {
      logic valid;
      logic err;
   } apb_rsp_t;

endpackage

// File: rtl/apb_slv_mux.sv
// -----------------------------------------------------------------------------
// apb_slv_mux
// Decodes the slave index into a one-hot psel and routes the selected slave's
// pready / pslverr / prdata back to the master. Only the indexed slave is ever
// observed; every other slave's response lines are ignored.
// Ports:
//   idx       in   SEL_W     slave index (top address bits)
//   sel_en    in   1         drive a select (SETUP / ACCESS)
//   psel      out  NSLV      one-hot select, all zero when sel_en is low
//   prdata    in   NSLV*DW   packed slave read data, slave k at [k*DW +: DW]
//   pready    in   NSLV      per-slave ready
//   pslverr   in   NSLV      per-slave error
//   sel_ready out  1         pready of the indexed slave
//   sel_err   out  1         pslverr of the indexed slave
//   sel_rdata out  DW        prdata slice of the indexed slave
// -----------------------------------------------------------------------------
module apb_slv_mux
   import apb_pkg::*;
#(
   parameter  int NSLV  = 4,
   parameter  int DW    = 32,
   localparam int SEL_W = apb_sel_w(NSLV)
)(
   input  logic [SEL_W-1:0]   idx,
   input  logic               sel_en,
   output logic [NSLV-1:0]    psel,
   input  logic [NSLV*DW-1:0] prdata,
   input  logic [NSLV-1:0]    pready,
   input  logic [NSLV-1:0]    pslverr,
   output logic               sel_ready,
   output logic               sel_err,
   output logic [DW-1:0]      sel_rdata
);

   // A compare-per-slave loop keeps every slice index constant, so the
   // decode and the return mux come out as plain and-or trees.
   always_comb begin
      psel      = '0;
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int k = 0; k < NSLV; k++) begin
         if (idx == SEL_W'(k)) begin
            psel[k]   = sel_en;
            sel_ready = pready[k];
            sel_err   = pslverr[k];
            sel_rdata = prdata[k*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/apb_req_master.sv
// -----------------------------------------------------------------------------
// apb_req_master
// Turns a valid/ready command stream into APB transfers to one of NSLV slaves
// and returns a one-cycle response pulse per completed transfer.
// The slave is chosen by the top $clog2(NSLV) bits of the byte address.
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYC cycles; an expired transfer completes with rsp_err=1, rdata 0.
// Ports:
//   pclk, preset                 clock, asynchronous active-low reset
//   cmd_valid / cmd_ready        command handshake
//   cmd_addr/write/wdata/strb/prot  command fields
//   rsp_valid, rsp_rdata, rsp_err   response (data/err held until the next one)
//   paddr, psel, penable, pwrite, pwdata, pstrb, pprot   APB request side
//   prdata, pready, pslverr      APB slave return (packed per slave)
// -----------------------------------------------------------------------------
module apb_req_master
   import apb_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int NSLV        = 4,
   parameter int TIMEOUT_CYC = 16
)(
   input  logic               pclk,
   input  logic               preset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [AW-1:0]      cmd_addr,
   input  logic               cmd_write,
   input  logic [DW-1:0]      cmd_wdata,
   input  logic [DW/8-1:0]    cmd_strb,
   input  logic [2:0]         cmd_prot,
   output logic               rsp_valid,
   output logic [DW-1:0]      rsp_rdata,
   output logic               rsp_err,
   output logic [AW-1:0]      paddr,
   output logic [NSLV-1:0]    psel,
   output logic               penable,
   output logic               pwrite,
   output logic [DW-1:0]      pwdata,
   output logic [DW/8-1:0]    pstrb,
   output logic [2:0]         pprot,
   input  logic [NSLV*DW-1:0] prdata,
   input  logic [NSLV-1:0]    pready,
   input  logic [NSLV-1:0]    pslverr
);

   localparam int SEL_W = apb_sel_w(NSLV);

   if ((DW % 8) != 0 || NSLV < 2 || NSLV > 16 || (NSLV & (NSLV - 1)) != 0 ||
       TIMEOUT_CYC < 1) begin : g_bad_params
      $error("apb_req_master: unsupported parameter combination");
   end

   apb_state_t    state;
   apb_state_t    state_nxt;
   apb_rsp_t      rsp_q;
   logic          sel_en;
   logic          sel_ready;
   logic          sel_err;
   logic [DW-1:0] sel_rdata;
   logic          timeout;
   logic          xfer_done;
   logic          cmd_load;

   apb_slv_mux #(
      .NSLV (NSLV),
      .DW   (DW)
   ) u_slv_mux (
      .idx       (paddr[AW-1 -: SEL_W]),
      .sel_en    (sel_en),
      .psel      (psel),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .sel_ready (sel_ready),
      .sel_err   (sel_err),
      .sel_rdata (sel_rdata)
   );

   // A transfer ends in the ACCESS cycle where the indexed slave is ready,
   // or where the optional watchdog gives up on it.
   assign xfer_done = (state == ACCESS) && (sel_ready || timeout);
   assign cmd_load  = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Counts ACCESS cycles without a ready; cleared in SETUP so every
   // transfer starts ACCESS from zero. The cycle that would take the count
   // to TIMEOUT_CYC is the forced completion.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wait_cnt <= '0;
      end else if (state == SETUP) begin
         wait_cnt <= '0;
      end else if (state == ACCESS && !sel_ready) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   assign timeout = (state == ACCESS) && !sel_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: a completing ACCESS with a new command pending skips IDLE.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (cmd_valid) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (xfer_done) state_nxt = cmd_valid ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state; cmd_ready in ACCESS follows the slave's
   // ready combinationally so back-to-back commands lose no cycle.
   always_comb begin
      cmd_ready = 1'b0;
      sel_en    = 1'b0;
      penable   = 1'b0;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
         end
         SETUP: begin
            sel_en = 1'b1;
         end
         ACCESS: begin
            sel_en    = 1'b1;
            penable   = 1'b1;
            cmd_ready = xfer_done;
         end
         default: begin
            cmd_ready = 1'b0;
         end
      endcase
   end

   // Command fields are captured only on acceptance, which keeps them stable
   // for the whole SETUP/ACCESS pair. Strobes carry no meaning on reads.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         paddr  <= '0;
         pwrite <= 1'b0;
         pwdata <= '0;
         pstrb  <= '0;
         pprot  <= '0;
      end else if (cmd_load) begin
         paddr  <= cmd_addr;
         pwrite <= cmd_write;
         pwdata <= cmd_wdata;
         pstrb  <= cmd_write ? cmd_strb : '0;
         pprot  <= cmd_prot;
      end
   end

   // Response: valid pulses for the cycle after completion, while error and
   // data are only rewritten by a completion and otherwise hold.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         rsp_q     <= '0;
         rsp_rdata <= '0;
      end else begin
         rsp_q.valid <= xfer_done;
         if (xfer_done) begin
            rsp_q.err <= sel_err || timeout;
            rsp_rdata <= (pwrite || timeout) ? '0 : sel_rdata;
         end
      end
   end

   assign rsp_valid = rsp_q.valid;
   assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_apb_req_master.sv
// -----------------------------------------------------------------------------
// tb_apb_req_master
// Directed bench for apb_req_master with a behavioural multi-slave model.
// Expected responses are queued as commands are accepted and retired by a
// monitor when rsp_valid pulses. Build with APB_TIMEOUT_EN to exercise the
// watchdog; without it the same slot checks that ACCESS waits indefinitely.
// -----------------------------------------------------------------------------
module tb_apb_req_master;

   localparam int AW          = 32;
   localparam int DW          = 32;
   localparam int NSLV        = 4;
   localparam int TIMEOUT_CYC = 16;

   logic               pclk = 1'b0;
   logic               preset;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [AW-1:0]      cmd_addr;
   logic               cmd_write;
   logic [DW-1:0]      cmd_wdata;
   logic [DW/8-1:0]    cmd_strb;
   logic [2:0]         cmd_prot;
   logic               rsp_valid;
   logic [DW-1:0]      rsp_rdata;
   logic               rsp_err;
   logic [AW-1:0]      paddr;
   logic [NSLV-1:0]    psel;
   logic               penable;
   logic               pwrite;
   logic [DW-1:0]      pwdata;
   logic [DW/8-1:0]    pstrb;
   logic [2:0]         pprot;
   logic [NSLV*DW-1:0] prdata;
   logic [NSLV-1:0]    pready;
   logic [NSLV-1:0]    pslverr;

   typedef struct {
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t            exp_q[$];
   int              rsp_cyc_q[$];
   exp_t            mon_exp;
   int              checks      = 0;
   int              errors      = 0;
   int              cycle       = 0;
   int              rsp_count   = 0;
   int              sel_cycles  = 0;
   int              pen_cycles  = 0;
   int              acc_cnt     = 0;
   int              wait_cfg[NSLV];
   logic [NSLV-1:0] err_cfg;
   logic [NSLV-1:0] spur_err;
   logic [NSLV-1:0] spur_ready;

   apb_req_master #(
      .AW          (AW),
      .DW          (DW),
      .NSLV        (NSLV),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_addr  (cmd_addr),
      .cmd_write (cmd_write),
      .cmd_wdata (cmd_wdata),
      .cmd_strb  (cmd_strb),
      .cmd_prot  (cmd_prot),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pprot     (pprot),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr)
   );

   // Free-running clock and a cycle index that advances on each active edge.
   always #5 pclk = ~pclk;

   always @(posedge pclk) cycle++;

   // Every comparison goes through here.
   task automatic checkOutput(input string tag, input logic [63:0] got,
                              input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Slave model: the selected slave raises pready after wait_cfg ACCESS
   // cycles and reports err_cfg with it; spur_* inject noise on other slaves.
   always @(negedge pclk) begin
      pready  = spur_ready;
      pslverr = spur_err;
      if (penable) begin
         for (int k = 0; k < NSLV; k++) begin
            if (psel[k] && acc_cnt == wait_cfg[k]) begin
               pready[k]  = 1'b1;
               pslverr[k] = err_cfg[k];
            end
         end
         acc_cnt++;
      end else begin
         acc_cnt = 0;
      end
   end

   // Monitor: select hygiene, phase counters and scoreboard retirement.
   always @(negedge pclk) begin
      if (psel != '0) begin
         sel_cycles++;
         checkOutput("psel_onehot", 64'($onehot(psel)), 64'd1);
      end
      if (penable) pen_cycles++;
      if (rsp_valid) begin
         rsp_count++;
         rsp_cyc_q.push_back(cycle);
         if (exp_q.size() == 0) begin
            checkOutput("rsp_unexpected", 64'd1, 64'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("rsp_err", 64'(rsp_err), 64'(mon_exp.err));
            checkOutput("rsp_rdata", 64'(rsp_rdata), 64'(mon_exp.rdata));
         end
      end
   end

   function automatic int lastRspCycle();
      return (rsp_cyc_q.size() > 0) ? rsp_cyc_q[rsp_cyc_q.size()-1] : -100;
   endfunction

   // Presents one command, waits (bounded) for acceptance, queues the
   // expected response and returns at the falling edge of the SETUP cycle.
   task automatic applyStimulus(input logic [AW-1:0] addr, input logic wr,
                                input logic [DW-1:0] wdata,
                                input logic [DW/8-1:0] strb,
                                input logic [2:0] prot,
                                input logic [DW-1:0] exp_rdata,
                                input logic exp_err, input bit want_rsp,
                                input bit keep_valid, output int accept_cyc);
      int   guard = 0;
      exp_t e;
      cmd_addr  = addr;
      cmd_write = wr;
      cmd_wdata = wdata;
      cmd_strb  = strb;
      cmd_prot  = prot;
      cmd_valid = 1'b1;
      #1;
      while (!cmd_ready && guard < 200) begin
         @(negedge pclk);
         #1;
         guard++;
      end
      checkOutput("cmd_accept", 64'(cmd_ready), 64'd1);
      accept_cyc = -1;
      if (cmd_ready) begin
         if (want_rsp) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            exp_q.push_back(e);
         end
         @(posedge pclk);
         @(negedge pclk);
         accept_cyc = cycle;
      end
      if (!keep_valid) cmd_valid = 1'b0;
   endtask

   task automatic waitRsp(input int target, input string tag);
      int guard = 0;
      while (rsp_count < target && guard < 100) begin
         @(negedge pclk);
         guard++;
      end
      #1;
      checkOutput(tag, 64'(rsp_count >= target), 64'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] simulation watchdog expired");
   end

   initial begin
      int acc_a;
      int acc_b;
      int base;
      preset     = 1'b0;
      cmd_valid  = 1'b0;
      cmd_addr   = '0;
      cmd_write  = 1'b0;
      cmd_wdata  = '0;
      cmd_strb   = '0;
      cmd_prot   = '0;
      pready     = '0;
      pslverr    = '0;
      err_cfg    = '0;
      spur_err   = '0;
      spur_ready = '0;
      for (int k = 0; k < NSLV; k++) wait_cfg[k] = 0;
      prdata[0*DW +: DW] = 32'h0BAD_F00D;
      prdata[1*DW +: DW] = 32'hAAAA_5555;
      prdata[2*DW +: DW] = 32'h2222_CCCC;
      prdata[3*DW +: DW] = 32'h1234_5678;

      // Reset values.
      repeat (3) @(negedge pclk);
      checkOutput("rst_psel", 64'(psel), 64'd0);
      checkOutput("rst_penable", 64'(penable), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
      checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      checkOutput("rst_paddr", 64'(paddr), 64'd0);
      checkOutput("rst_pwdata", 64'(pwdata), 64'd0);
      checkOutput("rst_pstrb", 64'(pstrb), 64'd0);
      checkOutput("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      preset = 1'b1;
      repeat (2) @(negedge pclk);

      $display("[TB] write, slave 1, zero wait");
      sel_cycles = 0;
      base = rsp_count;
      applyStimulus(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010,
                    32'h0, 1'b0, 1'b1, 1'b0, acc_a);
      checkOutput("wr_psel", 64'(psel), 64'b0010);
      checkOutput("wr_setup_penable", 64'(penable), 64'd0);
      checkOutput("wr_paddr", 64'(paddr), 64'h4000_0010);
      checkOutput("wr_pwdata", 64'(pwdata), 64'hDEAD_BEEF);
      checkOutput("wr_pstrb", 64'(pstrb), 64'hF);
      checkOutput("wr_pwrite", 64'(pwrite), 64'd1);
      checkOutput("wr_pprot", 64'(pprot), 64'd2);
      waitRsp(base + 1, "wr_rsp_arrived");
      checkOutput("wr_latency", 64'(lastRspCycle() - acc_a + 1), 64'd3);
      checkOutput("wr_sel_cycles", 64'(sel_cycles), 64'd2);
      repeat (2) @(negedge pclk);

      $display("[TB] read, slave 3, three wait cycles");
      sel_cycles = 0;
      pen_cycles = 0;
      spur_ready = 4'b0001;
      wait_cfg[3] = 3;
      base = rsp_count;
      applyStimulus(32'hC000_0004, 1'b0, 32'h0, 4'hF, 3'b000,
                    32'h1234_5678, 1'b0, 1'b1, 1'b0, acc_a);
      checkOutput("rd_psel", 64'(psel), 64'b1000);
      checkOutput("rd_pstrb_zero", 64'(pstrb), 64'd0);
      checkOutput("rd_pwrite", 64'(pwrite), 64'd0);
      waitRsp(base + 1, "rd_rsp_arrived");
      checkOutput("rd_pen_cycles", 64'(pen_cycles), 64'd4);
      checkOutput("rd_latency", 64'(lastRspCycle() - acc_a + 1), 64'd6);
      spur_ready = '0;
      wait_cfg[3] = 0;
      repeat (2) @(negedge pclk);

      $display("[TB] back-to-back commands");
      rsp_cyc_q.delete();
      base = rsp_count;
      applyStimulus(32'h4000_0000, 1'b1, 32'h1111_2222, 4'h3, 3'b001,
                    32'h0, 1'b0, 1'b1, 1'b1, acc_a);
      applyStimulus(32'h8000_0008, 1'b0, 32'h0, 4'h0, 3'b000,
                    32'h2222_CCCC, 1'b0, 1'b1, 1'b0, acc_b);
      checkOutput("b2b_psel", 64'(psel), 64'b0100);
      checkOutput("b2b_setup_penable", 64'(penable), 64'd0);
      checkOutput("b2b_setup_gap", 64'(acc_b - acc_a), 64'd2);
      waitRsp(base + 2, "b2b_rsp_arrived");
      checkOutput("b2b_rsp_gap",
                  64'((rsp_cyc_q.size() >= 2) ? rsp_cyc_q[1] - rsp_cyc_q[0] : -1),
                  64'd2);
      repeat (3) @(negedge pclk);
      #1;
      checkOutput("rsp_hold_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rsp_hold_rdata", 64'(rsp_rdata), 64'h2222_CCCC);

      $display("[TB] slave error with spurious pslverr on slave 0");
      spur_err   = 4'b0001;
      err_cfg[2] = 1'b1;
      base = rsp_count;
      applyStimulus(32'h8000_0020, 1'b1, 32'hCAFE_0001, 4'hF, 3'b000,
                    32'h0, 1'b1, 1'b1, 1'b0, acc_a);
      waitRsp(base + 1, "err_rsp_arrived");
      applyStimulus(32'hC000_0000, 1'b0, 32'h0, 4'h0, 3'b000,
                    32'h1234_5678, 1'b0, 1'b1, 1'b0, acc_a);
      waitRsp(base + 2, "noerr_rsp_arrived");
      spur_err = '0;
      err_cfg  = '0;
      repeat (2) @(negedge pclk);

      wait_cfg[1] = 1000;
      pen_cycles  = 0;
      base = rsp_count;
`ifdef APB_TIMEOUT_EN
      $display("[TB] watchdog on a silent slave");
      applyStimulus(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'b000,
                    32'h0, 1'b1, 1'b1, 1'b0, acc_a);
      waitRsp(base + 1, "to_rsp_arrived");
      checkOutput("to_pen_cycles", 64'(pen_cycles), 64'd16);
      repeat (2) @(negedge pclk);
`else
      $display("[TB] silent slave without watchdog");
      applyStimulus(32'h4000_0004, 1'b0, 32'h0, 4'h0, 3'b000,
                    32'h0, 1'b0, 1'b0, 1'b0, acc_a);
      repeat (100) @(negedge pclk);
      #1;
      checkOutput("hang_penable", 64'(penable), 64'd1);
      checkOutput("hang_psel", 64'(psel), 64'b0010);
      checkOutput("hang_no_rsp", 64'(rsp_count), 64'(base));
      checkOutput("hang_cmd_ready", 64'(cmd_ready), 64'd0);
`endif

      $display("[TB] reset during ACCESS");
      base = rsp_count;
      if (!penable) begin
         wait_cfg[3] = 1000;
         applyStimulus(32'hC000_0008, 1'b0, 32'h0, 4'h0, 3'b000,
                       32'h0, 1'b0, 1'b0, 1'b0, acc_a);
         repeat (3) @(negedge pclk);
      end
      #1;
      checkOutput("rst_pre_access", 64'(penable), 64'd1);
      @(negedge pclk);
      preset = 1'b0;
      #1;
      checkOutput("rst_mid_psel", 64'(psel), 64'd0);
      checkOutput("rst_mid_penable", 64'(penable), 64'd0);
      checkOutput("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_mid_paddr", 64'(paddr), 64'd0);
      repeat (2) @(negedge pclk);
      preset = 1'b1;
      for (int k = 0; k < NSLV; k++) wait_cfg[k] = 0;
      repeat (4) @(negedge pclk);
      #1;
      checkOutput("rst_no_rsp", 64'(rsp_count), 64'(base));
      checkOutput("rst_idle_cmd_ready", 64'(cmd_ready), 64'd1);
      checkOutput("rst_idle_psel", 64'(psel), 64'd0);

      $display("[TB] read slave 0 after reset");
      applyStimulus(32'h0000_0000, 1'b0, 32'h0, 4'h0, 3'b000,
                    32'h0BAD_F00D, 1'b0, 1'b1, 1'b0, acc_a);
      waitRsp(base + 1, "post_rst_rsp_arrived");
      repeat (2) @(negedge pclk);
      checkOutput("exp_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
